// File: rtl/lab7_pkg.sv
// Shared widths, fetch FSM states and buffered-entry layout for the lab7 fetch stage.
package lab7_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_PRESENT
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry instruction buffer with single-cycle flush for the prefetching fetch stage.
module fetch_fifo
   import lab7_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t din,
   input  logic         pop,
   output fetch_entry_t dout,
   output logic [1:0]   count
);

   fetch_entry_t q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   cnt_q;

   assign dout  = q[rd_q];
   assign count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q[0]  <= '0;
         q[1]  <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else if (flush) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) begin
            q[wr_q] <= din;
            wr_q    <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// lab7 instruction fetch stage: PC, RAM read strobe, valid/ready hand-off, branch redirect.
// Build option FETCH_PREFETCH_EN replaces the 3-state FSM with a 2-entry prefetch buffer.
module instr_fetch #(
   parameter int PC_W    = lab7_pkg::PC_W,
   parameter int INSTR_W = lab7_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    start_pc,
   output logic               mem_rd,
   output logic [PC_W-1:0]    mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc
);

   import lab7_pkg::*;

   localparam logic [PC_W-1:0] PC_ONE = 1;

   logic [PC_W-1:0] pc_q;
   logic            xfer;

   assign mem_addr = pc_q;
   assign xfer     = instr_valid && instr_ready;

`ifdef FETCH_PREFETCH_EN

   fetch_entry_t    head;
   fetch_entry_t    fill;
   logic [1:0]      count;
   logic            inflight_q;
   logic [PC_W-1:0] inflight_pc_q;
   logic            push;
   logic [2:0]      occ;

   // Credit the same-cycle pop so a full pipe sustains one read per cycle.
   assign occ         = {1'b0, count} + {2'b00, inflight_q} - {2'b00, xfer};
   assign mem_rd      = !redirect && (occ < 3'd2);
   assign push        = inflight_q && !redirect;
   assign fill.instr  = mem_rdata;
   assign fill.pc     = inflight_pc_q;
   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign instr_valid = (count != 2'd0);

   fetch_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (push),
      .din   (fill),
      .pop   (xfer),
      .dout  (head),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= start_pc;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         inflight_q    <= mem_rd;
         inflight_pc_q <= pc_q;
         if (redirect)    pc_q <= redirect_pc;
         else if (mem_rd) pc_q <= pc_q + PC_ONE;
      end
   end

`else

   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    instr_pc_q;

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = (state_q == S_PRESENT);

   always_comb begin
      state_d = state_q;
      mem_rd  = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_rd  = !redirect;
            state_d = S_WAIT;
         end
         S_WAIT:    state_d = S_PRESENT;
         S_PRESENT: if (xfer) state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
      if (redirect) state_d = S_FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= start_pc;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q <= state_d;
         if (redirect)               pc_q <= redirect_pc;
         else if (state_q == S_FETCH) pc_q <= pc_q + PC_ONE;
         // The word in flight belongs to pc_q-1; a redirect drops it.
         if (state_q == S_WAIT && !redirect) begin
            instr_q    <= mem_rdata;
            instr_pc_q <= pc_q - PC_ONE;
         end
      end
   end

`endif

endmodule
